shift_pipe: RTL and testbench

- Parametrised, pipelined logarithmic barrel shifter for the CPU execute stage.
- Builds a full SLL/SRL/SRA shifter from log2(WIDTH) conditional shift-by-2^k levels, which generalise the fixed single-level conditional left shift.
- Levels are split across registered stages with a valid/ready handshake on both sides, so the ALU can stall the shifter without losing results.
- A destination tag travels with each operation for writeback.

---
 rtl/shift_pipe.sv | 160 ++++++++++++++++
 tb/tb_shift_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined log barrel shifter (SLL/SRL/SRA, optional ROL under SHIFT_ROTATE_EN); latency PIPE_STAGES cycles.
// valid/ready on both sides with a combinational ready chain; a stalled output holds its result stable.
module shift_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4,
  localparam int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero,
  output logic               out_err
);

  localparam int P = PIPE_STAGES;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ROL = 2'd3
  } op_e;

  logic [P-1:0]       st_vld;
  logic [WIDTH-1:0]   st_data  [P];
  logic [SHAMT_W-1:0] st_shamt [P];
  logic [1:0]         st_op    [P];
  logic [TAG_W-1:0]   st_tag   [P];
  logic               st_err   [P];
  logic               zero_q;

  logic [P-1:0]       up_vld;
  logic [WIDTH-1:0]   up_data  [P];
  logic [SHAMT_W-1:0] up_shamt [P];
  logic [1:0]         up_op    [P];
  logic [TAG_W-1:0]   up_tag   [P];
  logic               up_err   [P];
  logic [WIDTH-1:0]   nx_data  [P];
  logic [P-1:0]       ld;
  logic [P-1:0]       adv;
  logic [1:0]         op0;
  logic               err0;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic is_right(input logic [1:0] op);
    return (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Right shifts run in the bit-reversed domain, where bit 0 always holds the
  // original sign bit (it is either untouched or refilled with it), so SRA
  // needs no extra sideband to find its fill value.
  function automatic logic [WIDTH-1:0] apply_levels(input logic [WIDTH-1:0] d,
                                                    input logic [SHAMT_W-1:0] sh,
                                                    input logic [1:0] op,
                                                    input int stage);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] shifted;
    int amt;
    r = d;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (((k * P) / SHAMT_W) == stage && sh[k]) begin
        amt     = 1 << k;
        shifted = r << amt;
`ifdef SHIFT_ROTATE_EN
        if (op == OP_ROL) shifted = shifted | (r >> (WIDTH - amt));
`endif
        if ((op == OP_SRA) && r[0]) shifted = shifted | ~({WIDTH{1'b1}} << amt);
        r = shifted;
      end
    end
    return r;
  endfunction

  always_comb begin
`ifdef SHIFT_ROTATE_EN
    op0  = in_op;
    err0 = 1'b0;
`else
    op0  = (in_op == OP_ROL) ? OP_SLL : in_op;
    err0 = (in_op == OP_ROL);
`endif
    up_vld[0]   = in_valid;
    up_data[0]  = is_right(op0) ? bitrev(in_data) : in_data;
    up_shamt[0] = in_shamt;
    up_op[0]    = op0;
    up_tag[0]   = in_tag;
    up_err[0]   = err0;
    for (int s = 1; s < P; s++) begin
      up_vld[s]   = st_vld[s-1];
      up_data[s]  = st_data[s-1];
      up_shamt[s] = st_shamt[s-1];
      up_op[s]    = st_op[s-1];
      up_tag[s]   = st_tag[s-1];
      up_err[s]   = st_err[s-1];
    end
    for (int s = 0; s < P; s++) begin
      nx_data[s] = apply_levels(up_data[s], up_shamt[s], up_op[s], s);
      if (s == P - 1 && is_right(up_op[s])) nx_data[s] = bitrev(nx_data[s]);
    end
    // Ready ripples back from the consumer so a full pipe still streams.
    adv      = '0;
    ld       = '0;
    adv[P-1] = st_vld[P-1] & out_ready;
    for (int s = P - 1; s >= 0; s--) begin
      ld[s] = ~st_vld[s] | adv[s];
      if (s > 0) adv[s-1] = ld[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vld <= '0;
      zero_q <= 1'b0;
      for (int s = 0; s < P; s++) begin
        st_data[s]  <= '0;
        st_shamt[s] <= '0;
        st_op[s]    <= '0;
        st_tag[s]   <= '0;
        st_err[s]   <= 1'b0;
      end
    end else begin
      for (int s = 0; s < P; s++) begin
        if (ld[s]) begin
          st_vld[s] <= up_vld[s];
          if (up_vld[s]) begin
            st_data[s]  <= nx_data[s];
            st_shamt[s] <= up_shamt[s];
            st_op[s]    <= up_op[s];
            st_tag[s]   <= up_tag[s];
            st_err[s]   <= up_err[s];
          end
        end
      end
      if (ld[P-1] && up_vld[P-1]) zero_q <= (nx_data[P-1] == '0);
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = st_vld[P-1];
  assign out_data  = st_data[P-1];
  assign out_tag   = st_tag[P-1];
  assign out_zero  = zero_q;
  assign out_err   = st_err[P-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Randomized + directed bench for shift_pipe (WIDTH=32, PIPE_STAGES=2, TAG_W=4) against an arithmetic model.
module tb_shift_pipe;
  localparam int W = 32;
  localparam int P = 2;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [4:0]   in_shamt = '0;
  logic [1:0]   in_op = '0;
  logic [T-1:0] in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic [T-1:0] out_tag;
  logic         out_zero;
  logic         out_err;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] d;
    logic [T-1:0] t;
    logic         e;
  } exp_t;
  exp_t q[$];

  shift_pipe #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d, input logic [4:0] sh,
                                 input logic [1:0] op, input logic [T-1:0] t);
    exp_t r;
    logic [2*W-1:0] dd;
    r.t = t;
    r.e = 1'b0;
    case (op)
      2'd0: r.d = d << sh;
      2'd1: r.d = d >> sh;
      2'd2: r.d = $unsigned($signed(d) >>> sh);
      default: begin
`ifdef SHIFT_ROTATE_EN
        dd  = {d, d} << sh;
        r.d = dd[2*W-1:W];
`else
        dd  = '0;
        r.d = d << sh;
        r.e = 1'b1;
`endif
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every accepted op must emerge once, in order, with the model result.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, (q.size() < P) || out_ready);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("sb_unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_data", out_data, e.d);
          check("sb_tag", out_tag, e.t);
          check("sb_zero", out_zero, e.d == '0);
          check("sb_err", out_err, e.e);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data, in_shamt, in_op, in_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] d, input logic [4:0] sh, input logic [1:0] op,
                       input logic [T-1:0] t);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    in_tag   = t;
  endtask

  task automatic run_one(input string name, input logic [W-1:0] d, input logic [4:0] sh,
                         input logic [1:0] op, input logic [W-1:0] exp_d, input logic exp_e);
    drive(d, sh, op, 4'h7);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({name, "_vld"}, out_valid, 1);
    check({name, "_data"}, out_data, exp_d);
    check({name, "_zero"}, out_zero, exp_d == '0);
    check({name, "_err"}, out_err, exp_e);
    step();
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_err", out_err, 0);
    step();

    // Latency: accepted at edge 0, visible after edge 1.
    drive(32'h0000_0001, 5'd31, 2'd0, 4'd5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early", out_valid, 0);
    @(negedge clk);
    check("lat_vld", out_valid, 1);
    check("lat_data", out_data, 32'h8000_0000);
    check("lat_tag", out_tag, 5);
    check("lat_zero", out_zero, 0);
    step();

    run_one("sra31", 32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF, 1'b0);
    run_one("srl31", 32'h8000_0000, 5'd31, 2'd1, 32'h0000_0001, 1'b0);
    run_one("sll0", 32'hFFFF_FFFF, 5'd0, 2'd0, 32'hFFFF_FFFF, 1'b0);
`ifdef SHIFT_ROTATE_EN
    run_one("rol4", 32'h8000_0001, 5'd4, 2'd3, 32'h0000_0018, 1'b0);
`else
    run_one("rol4", 32'h8000_0001, 5'd4, 2'd3, 32'h0000_0010, 1'b1);
`endif
    run_one("sll31b", 32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, 1'b0);
    run_one("srl1z", 32'h0000_0001, 5'd1, 2'd1, 32'h0000_0000, 1'b0);

    // Backpressure: two accepted, third stalls, output holds.
    out_ready = 1'b0;
    drive(32'h11, 5'd1, 2'd0, 4'd1);
    step();
    drive(32'h33, 5'd2, 2'd0, 4'd2);
    step();
    drive(32'h05, 5'd3, 2'd0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_data", out_data, 32'h22);
      check("bp_hold_tag", out_tag, 1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_o1_tag", out_tag, 1);
    check("bp_o1_data", out_data, 32'h22);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_o2_vld", out_valid, 1);
    check("bp_o2_tag", out_tag, 2);
    check("bp_o2_data", out_data, 32'hCC);
    step();
    @(negedge clk);
    check("bp_o3_vld", out_valid, 1);
    check("bp_o3_tag", out_tag, 3);
    check("bp_o3_data", out_data, 32'h28);
    step();

    // Random traffic with random consumer stalls.
    for (int c = 0; c < 800; c++) begin
      logic [W-1:0] d;
      logic [4:0]   sh;
      case ($urandom_range(0, 5))
        0: d = 32'h8000_0000;
        1: d = 32'hFFFF_FFFF;
        2: d = 32'h0000_0001;
        3: d = 32'h0;
        default: d = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: sh = 5'd0;
        1: sh = 5'd31;
        default: sh = 5'($urandom_range(0, 31));
      endcase
      drive(d, sh, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    check("drain_empty", q.size(), 0);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    drive(32'h1234_5678, 5'd4, 2'd0, 4'd9);
    step();
    drive(32'h0000_00F0, 5'd2, 2'd1, 4'd10);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
